// File: rtl/pll_rst_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_rst_pkg
// Description : Shared types and constants for the PLL reset sequencer.
//               - state_e     : sequencer state encoding
//               - c_def_*     : default values of the sequencer parameters
//               - c_*_cnt_w   : counter widths derived from those defaults
//               - cnt_w, imax : helpers for sizing counters from parameters
// Revision    : 1.0 - initial release
// ============================================================================
package pll_rst_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    MEM_REL   = 2'd1,
    RUN       = 2'd2,
    SOFT_RST  = 2'd3
  } state_e;

  // Bits needed to hold the value max_value (at least one bit).
  function automatic int cnt_w(input int max_value);
    return (max_value < 1) ? 1 : $clog2(max_value + 1);
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int c_def_lock_stable_cycles = 4096;
  localparam int c_def_stage_gap_cycles   = 256;
  localparam int c_def_soft_rst_cycles    = 64;
  localparam int c_def_wdog_cycles        = 400000;
  localparam int c_def_pll_rst_cycles     = 16;
  localparam int c_def_loss_cnt_w         = 8;

  // Widths for the default build; the top widens them if a parameter
  // override needs more range.
  localparam int c_stab_cnt_w  = $clog2(c_def_lock_stable_cycles);
  localparam int c_phase_cnt_w = $clog2(c_def_stage_gap_cycles);
  localparam int c_wdog_cnt_w  = $clog2(c_def_wdog_cycles + c_def_pll_rst_cycles + 1);

endpackage : pll_rst_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : 1-bit two-flop synchroniser, asynchronous active-low reset
//               clearing both stages to 0.
// Ports       : clk   - destination clock
//               rst_n - asynchronous active-low reset
//               d_i   - asynchronous input
//               q_o   - synchronised output (two clk edges of latency)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_sequencer
// Description : Staged reset release behind the system PLL. Waits for a
//               stable lock, releases the memory-side reset, then the core
//               reset a fixed gap later. Lock loss re-asserts both resets and
//               is counted; a soft request pulses the core reset only.
//               Optional macro PLL_RST_WATCHDOG_EN adds a lock watchdog that
//               pulses pll_rst while lock stays absent in WAIT_LOCK.
// Ports       : clk           - PLL output clock
//               rst_n         - asynchronous active-low reset
//               pll_locked    - PLL lock flag (asynchronous)
//               soft_rst_req  - core-only reset request level (asynchronous)
//               mem_rst_n     - memory-side reset, active low
//               core_rst_n    - core reset, active low
//               ready         - high only in RUN
//               lock_loss_cnt - saturating count of lock-loss events
//               pll_rst       - active-high PLL reset request (0 unless the
//                               watchdog is built in)
// Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer
  import pll_rst_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = c_def_lock_stable_cycles,
  parameter int STAGE_GAP_CYCLES   = c_def_stage_gap_cycles,
  parameter int SOFT_RST_CYCLES    = c_def_soft_rst_cycles,
  parameter int WDOG_CYCLES        = c_def_wdog_cycles,
  parameter int PLL_RST_CYCLES     = c_def_pll_rst_cycles,
  parameter int LOSS_CNT_W         = c_def_loss_cnt_w
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  input  logic                  soft_rst_req,
  output logic                  mem_rst_n,
  output logic                  core_rst_n,
  output logic                  ready,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
  output logic                  pll_rst
);

  localparam int c_stab_w  = imax(c_stab_cnt_w, cnt_w(LOCK_STABLE_CYCLES - 1));
  localparam int c_phase_w = imax(c_phase_cnt_w,
                                  cnt_w(imax(STAGE_GAP_CYCLES, SOFT_RST_CYCLES) - 1));

  localparam logic [c_stab_w-1:0]   c_stab_max  = c_stab_w'(LOCK_STABLE_CYCLES - 1);
  localparam logic [c_phase_w-1:0]  c_gap_last  = c_phase_w'(STAGE_GAP_CYCLES - 1);
  localparam logic [c_phase_w-1:0]  c_soft_last = c_phase_w'(SOFT_RST_CYCLES - 1);
  localparam logic [LOSS_CNT_W-1:0] c_loss_max  = '1;

  // --------------------------------------------------------------------------
  // Input synchronisers
  // --------------------------------------------------------------------------
  logic lk_s;
  logic sr_s;

  sync_2ff u_sync_lock (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_locked),
    .q_o   (lk_s)
  );

  sync_2ff u_sync_soft (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (soft_rst_req),
    .q_o   (sr_s)
  );

  // --------------------------------------------------------------------------
  // Lock stability counter. The stable flag is registered, which puts the
  // release of mem_rst_n 2 + LOCK_STABLE_CYCLES + 1 edges after the first
  // edge that samples the lock high.
  // --------------------------------------------------------------------------
  logic [c_stab_w-1:0] stab_cnt_q;
  logic [c_stab_w-1:0] stab_cnt_d;
  logic                stable_q;

  always_comb begin
    stab_cnt_d = '0;
    if (lk_s) begin
      stab_cnt_d = (stab_cnt_q == c_stab_max) ? stab_cnt_q : stab_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_cnt_q <= '0;
      stable_q   <= 1'b0;
    end else begin
      stab_cnt_q <= stab_cnt_d;
      stable_q   <= lk_s && (stab_cnt_q == c_stab_max);
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer FSM. phase_cnt_q serves as the stage-gap counter in MEM_REL and
  // the soft-reset counter in SOFT_RST; it is cleared on every state entry.
  // --------------------------------------------------------------------------
  state_e                  state_q;
  logic [c_phase_w-1:0]    phase_cnt_q;
  logic                    sr_prev_q;
  logic                    mem_rst_n_q;
  logic                    core_rst_n_q;
  logic                    ready_q;
  logic [LOSS_CNT_W-1:0]   loss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_LOCK;
      phase_cnt_q  <= '0;
      sr_prev_q    <= 1'b0;
      mem_rst_n_q  <= 1'b0;
      core_rst_n_q <= 1'b0;
      ready_q      <= 1'b0;
      loss_cnt_q   <= '0;
    end else begin
      sr_prev_q <= sr_s;
      // Lock loss outranks everything, including a soft request seen on
      // the same edge.
      if ((state_q != WAIT_LOCK) && !lk_s) begin
        state_q      <= WAIT_LOCK;
        phase_cnt_q  <= '0;
        mem_rst_n_q  <= 1'b0;
        core_rst_n_q <= 1'b0;
        ready_q      <= 1'b0;
        if (loss_cnt_q != c_loss_max) begin
          loss_cnt_q <= loss_cnt_q + 1'b1;
        end
      end else begin
        case (state_q)
          WAIT_LOCK: begin
            if (stable_q && lk_s) begin
              state_q     <= MEM_REL;
              phase_cnt_q <= '0;
              mem_rst_n_q <= 1'b1;
            end
          end
          MEM_REL: begin
            if (phase_cnt_q == c_gap_last) begin
              state_q      <= RUN;
              phase_cnt_q  <= '0;
              core_rst_n_q <= 1'b1;
              ready_q      <= 1'b1;
            end else begin
              phase_cnt_q <= phase_cnt_q + 1'b1;
            end
          end
          RUN: begin
            if (sr_s && !sr_prev_q) begin
              state_q      <= SOFT_RST;
              phase_cnt_q  <= '0;
              core_rst_n_q <= 1'b0;
              ready_q      <= 1'b0;
            end
          end
          SOFT_RST: begin
            // Once the minimum pulse has elapsed, a still-held request keeps
            // the core in reset until it drops.
            if (phase_cnt_q != c_soft_last) begin
              phase_cnt_q <= phase_cnt_q + 1'b1;
            end else if (!sr_s) begin
              state_q      <= RUN;
              phase_cnt_q  <= '0;
              core_rst_n_q <= 1'b1;
              ready_q      <= 1'b1;
            end
          end
          default: begin
            state_q      <= WAIT_LOCK;
            phase_cnt_q  <= '0;
            mem_rst_n_q  <= 1'b0;
            core_rst_n_q <= 1'b0;
            ready_q      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mem_rst_n     = mem_rst_n_q;
  assign core_rst_n    = core_rst_n_q;
  assign ready         = ready_q;
  assign lock_loss_cnt = loss_cnt_q;

  // --------------------------------------------------------------------------
  // Lock watchdog. wd_cnt_q counts lock-less cycles in WAIT_LOCK; values
  // above WDOG_CYCLES form the pll_rst pulse. After the pulse the count
  // restarts at 1 because that cycle is itself lock-less, giving a period
  // of WDOG_CYCLES + PLL_RST_CYCLES.
  // --------------------------------------------------------------------------
`ifdef PLL_RST_WATCHDOG_EN
  localparam int c_wd_w = imax(c_wdog_cnt_w, cnt_w(WDOG_CYCLES + PLL_RST_CYCLES));
  localparam logic [c_wd_w-1:0] c_wd_fire = c_wd_w'(WDOG_CYCLES);
  localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(WDOG_CYCLES + PLL_RST_CYCLES);

  logic              w_wd_active;
  logic [c_wd_w-1:0] wd_cnt_q;
  logic [c_wd_w-1:0] wd_cnt_d;
  logic              pll_rst_q;

  assign w_wd_active = (state_q == WAIT_LOCK) && !lk_s;

  always_comb begin
    wd_cnt_d = '0;
    if (w_wd_active) begin
      wd_cnt_d = (wd_cnt_q == c_wd_last) ? c_wd_w'(1) : wd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q  <= '0;
      pll_rst_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      pll_rst_q <= w_wd_active && (wd_cnt_d > c_wd_fire);
    end
  end

  assign pll_rst = pll_rst_q;
`else
  assign pll_rst = 1'b0;
`endif

endmodule : pll_reset_sequencer
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_reset_sequencer
// Description : Directed self-checking bench for pll_reset_sequencer using
//               LOCK_STABLE_CYCLES=16, STAGE_GAP_CYCLES=8, SOFT_RST_CYCLES=4,
//               WDOG_CYCLES=100, PLL_RST_CYCLES=4, LOSS_CNT_W=2.
//               Edge numbering: edge 0 is the last edge in reset; an input
//               changed after edge N-1 is first sampled at edge N ("cycle N"),
//               and an output registered at edge N is visible in cycle N+1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_reset_sequencer;

  localparam int c_loss_w = 2;

  logic                clk;
  logic                rst_n;
  logic                pll_locked;
  logic                soft_rst_req;
  logic                mem_rst_n;
  logic                core_rst_n;
  logic                ready;
  logic [c_loss_w-1:0] lock_loss_cnt;
  logic                pll_rst;

  int n_checks;
  int n_errors;

  pll_reset_sequencer #(
    .LOCK_STABLE_CYCLES (16),
    .STAGE_GAP_CYCLES   (8),
    .SOFT_RST_CYCLES    (4),
    .WDOG_CYCLES        (100),
    .PLL_RST_CYCLES     (4),
    .LOSS_CNT_W         (c_loss_w)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pll_locked    (pll_locked),
    .soft_rst_req  (soft_rst_req),
    .mem_rst_n     (mem_rst_n),
    .core_rst_n    (core_rst_n),
    .ready         (ready),
    .lock_loss_cnt (lock_loss_cnt),
    .pll_rst       (pll_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    pll_locked   = 1'b0;
    soft_rst_req = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    pll_locked   = 1'b1;
    soft_rst_req = 1'b1;
    #3;
    repeat (3) tick();
    n_checks++;
    if ({mem_rst_n, core_rst_n, ready, lock_loss_cnt, pll_rst} !== 6'b0) begin
      n_errors++;
      $display("FAIL reset_hold outputs: got %b want 000000",
               {mem_rst_n, core_rst_n, ready, lock_loss_cnt, pll_rst});
    end
    rst_n = 1'b1;
    repeat (2) tick();
    n_checks++;
    if ({mem_rst_n, core_rst_n, ready} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_release early outputs: got %b want 000",
               {mem_rst_n, core_rst_n, ready});
    end
    pll_locked   = 1'b0;
    soft_rst_req = 1'b0;
  endtask

  // Lock rises in cycle 10; mem released at edge 28 (19 edges), core/ready at 36.
  task automatic test_power_up();
    do_reset();
    repeat (9) tick();
    pll_locked = 1'b1;
    for (int n = 10; n <= 40; n++) begin
      tick();
      n_checks++;
      if ({mem_rst_n, core_rst_n, ready} !== {n >= 28, n >= 36, n >= 36}) begin
        n_errors++;
        $display("FAIL power_up edge %0d mem/core/ready: got %b want %b", n,
                 {mem_rst_n, core_rst_n, ready}, {n >= 28, n >= 36, n >= 36});
      end
    end
  endtask

  // Lock low during cycles 20-22; re-rise first sampled at edge 23 so mem
  // releases at edge 41, core at 49.
  task automatic test_lock_glitch();
    do_reset();
    repeat (9) tick();
    pll_locked = 1'b1;
    for (int n = 10; n <= 50; n++) begin
      if (n == 20) pll_locked = 1'b0;
      if (n == 23) pll_locked = 1'b1;
      tick();
      n_checks++;
      if ({mem_rst_n, core_rst_n} !== {n >= 41, n >= 49}) begin
        n_errors++;
        $display("FAIL lock_glitch edge %0d mem/core: got %b want %b", n,
                 {mem_rst_n, core_rst_n}, {n >= 41, n >= 49});
      end
    end
    n_checks++;
    if (lock_loss_cnt !== 2'd0) begin
      n_errors++;
      $display("FAIL lock_glitch lock_loss_cnt: got %0d want 0", lock_loss_cnt);
    end
  endtask

  task automatic test_lock_loss();
    pll_locked = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({mem_rst_n, core_rst_n, ready} !== 3'b111) begin
      n_errors++;
      $display("FAIL lock_loss edge+2 still released: got %b want 111",
               {mem_rst_n, core_rst_n, ready});
    end
    tick();
    n_checks++;
    if ({mem_rst_n, core_rst_n, ready, lock_loss_cnt} !== 5'b00001) begin
      n_errors++;
      $display("FAIL lock_loss edge+3 mem/core/ready/cnt: got %b want 00001",
               {mem_rst_n, core_rst_n, ready, lock_loss_cnt});
    end
    repeat (5) tick();
    pll_locked = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      n_checks++;
      if ({mem_rst_n, core_rst_n, ready} !== {k >= 19, k >= 27, k >= 27}) begin
        n_errors++;
        $display("FAIL relock edge +%0d mem/core/ready: got %b want %b", k,
                 {mem_rst_n, core_rst_n, ready}, {k >= 19, k >= 27, k >= 27});
      end
    end
    n_checks++;
    if (lock_loss_cnt !== 2'd1) begin
      n_errors++;
      $display("FAIL relock lock_loss_cnt: got %0d want 1", lock_loss_cnt);
    end
  endtask

  // Pulse sampled at edge s+1 only: sr_s high after s+2, core low at
  // edges s+3..s+6. Held for 10 cycles: core low at h+3..h+12.
  task automatic test_soft_reset();
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    for (int k = 2; k <= 10; k++) begin
      tick();
      n_checks++;
      if ({mem_rst_n, core_rst_n, ready} !== {1'b1, !(k >= 3 && k <= 6), !(k >= 3 && k <= 6)}) begin
        n_errors++;
        $display("FAIL soft_pulse edge +%0d mem/core/ready: got %b want %b", k,
                 {mem_rst_n, core_rst_n, ready},
                 {1'b1, !(k >= 3 && k <= 6), !(k >= 3 && k <= 6)});
      end
    end
    soft_rst_req = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      n_checks++;
      if ({mem_rst_n, core_rst_n} !== {1'b1, !(k >= 3 && k <= 12)}) begin
        n_errors++;
        $display("FAIL soft_held edge +%0d mem/core: got %b want %b", k,
                 {mem_rst_n, core_rst_n}, {1'b1, !(k >= 3 && k <= 12)});
      end
      if (k == 10) soft_rst_req = 1'b0;
    end
  endtask

  // Repeated lock loss from RUN and from MEM_REL; 2-bit counter saturates at 3.
  task automatic test_back_to_back();
    logic [c_loss_w-1:0] exp_cnt;
    exp_cnt = 2'd1;
    for (int i = 0; i < 3; i++) begin
      pll_locked = 1'b0;
      repeat (4) tick();
      if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
      n_checks++;
      if ({mem_rst_n, lock_loss_cnt} !== {1'b0, exp_cnt}) begin
        n_errors++;
        $display("FAIL back_to_back loss %0d mem/cnt: got %b want %b", i,
                 {mem_rst_n, lock_loss_cnt}, {1'b0, exp_cnt});
      end
      pll_locked = 1'b1;
      repeat (22) tick();
      n_checks++;
      if ({mem_rst_n, core_rst_n} !== 2'b10) begin
        n_errors++;
        $display("FAIL back_to_back relock %0d mem/core: got %b want 10", i,
                 {mem_rst_n, core_rst_n});
      end
    end
  endtask

  task automatic test_mid_reset();
    pll_locked = 1'b0;
    repeat (5) tick();
    pll_locked = 1'b1;
    repeat (21) tick();
    n_checks++;
    if ({mem_rst_n, core_rst_n, lock_loss_cnt} !== 4'b1011) begin
      n_errors++;
      $display("FAIL mid_reset in MEM_REL mem/core/cnt: got %b want 1011",
               {mem_rst_n, core_rst_n, lock_loss_cnt});
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_rst_n, core_rst_n, ready, lock_loss_cnt, pll_rst} !== 6'b0) begin
      n_errors++;
      $display("FAIL mid_reset async outputs: got %b want 000000",
               {mem_rst_n, core_rst_n, ready, lock_loss_cnt, pll_rst});
    end
  endtask

  // Lock absent from reset: pulses registered at edges 101-104 and 205-208.
  task automatic test_watchdog();
    logic exp_rst;
    do_reset();
    for (int n = 1; n <= 215; n++) begin
      tick();
`ifdef PLL_RST_WATCHDOG_EN
      exp_rst = (n >= 101 && n <= 104) || (n >= 205 && n <= 208);
`else
      exp_rst = 1'b0;
`endif
      n_checks++;
      if (pll_rst !== exp_rst) begin
        n_errors++;
        $display("FAIL watchdog edge %0d pll_rst: got %b want %b", n, pll_rst, exp_rst);
      end
    end
    n_checks++;
    if ({mem_rst_n, core_rst_n, ready} !== 3'b000) begin
      n_errors++;
      $display("FAIL watchdog resets held: got %b want 000",
               {mem_rst_n, core_rst_n, ready});
    end
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst_n        = 1'b0;
    pll_locked   = 1'b0;
    soft_rst_req = 1'b0;
    test_reset();
    test_power_up();
    test_lock_glitch();
    test_lock_loss();
    test_soft_reset();
    test_back_to_back();
    test_mid_reset();
    test_watchdog();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_pll_reset_sequencer
`default_nettype wire
